// File: rtl/marquee_ctrl.sv
// marquee_ctrl: two-marker 16-LED marquee sequencer (clk, rst, en, dir in; led, pos_single, pos_triple, state, hit out)
module marquee_ctrl #(
  parameter int FAST_DIV    = 2**23,
  parameter int SLOW_DIV    = 2**26,
  parameter int FLASH_TICKS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic        dir,
  output logic [15:0] led,
  output logic [3:0]  pos_single,
  output logic [3:0]  pos_triple,
  output logic [1:0]  state,
  output logic        hit
);
  localparam int FW = $clog2(FAST_DIV);
  localparam int SW = $clog2(SLOW_DIV);
  localparam int CW = $clog2(FLASH_TICKS + 1);
  typedef enum logic [1:0] {IDLE, RUN, HOLD, FLASH} state_t;
  state_t          state_q, state_d;
  logic [FW-1:0]   fast_q, fast_d;
  logic [SW-1:0]   slow_q, slow_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      pos_single_q, pos_single_d, pos_triple_q, pos_triple_d, diff, delta;
  logic            phase_q, phase_d, hit_q, hit_d, overlap_prev_q;
  logic            tick_fast, tick_slow, step_s, step_t, overlap, rise;
  assign tick_fast = fast_q == FW'(FAST_DIV - 1);
  assign tick_slow = slow_q == SW'(SLOW_DIV - 1);
  assign step_s    = dir ? tick_slow : tick_fast;
  assign step_t    = dir ? tick_fast : tick_slow;
  assign delta     = dir ? 4'd1 : 4'd15;
  assign diff      = pos_single_q - pos_triple_q;
  assign overlap   = diff == 4'd0 || diff == 4'd1 || diff == 4'd15;
  assign rise      = overlap && !overlap_prev_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= IDLE;
      fast_q         <= '0;
      slow_q         <= '0;
      cnt_q          <= '0;
      phase_q        <= 1'b0;
      hit_q          <= 1'b0;
      overlap_prev_q <= 1'b1;
      pos_single_q   <= 4'd15;
      pos_triple_q   <= 4'd14;
    end else begin
      state_q        <= state_d;
      fast_q         <= fast_d;
      slow_q         <= slow_d;
      cnt_q          <= cnt_d;
      phase_q        <= phase_d;
      hit_q          <= hit_d;
      overlap_prev_q <= overlap;
      pos_single_q   <= pos_single_d;
      pos_triple_q   <= pos_triple_d;
    end
  end
  always_comb begin
    fast_d       = tick_fast ? '0 : fast_q + 1'b1;
    slow_d       = tick_slow ? '0 : slow_q + 1'b1;
    state_d      = state_q;
    pos_single_d = pos_single_q;
    pos_triple_d = pos_triple_q;
    cnt_d        = cnt_q;
    phase_d      = phase_q;
    hit_d        = 1'b0;
    case (state_q)
      IDLE, HOLD: state_d = en ? RUN : state_q;
      RUN:
        if (rise) begin
          state_d = FLASH;
          hit_d   = 1'b1;
          phase_d = 1'b1;
          cnt_d   = '0;
        end else begin
          pos_single_d = step_s ? pos_single_q + delta : pos_single_q;
          pos_triple_d = step_t ? pos_triple_q + delta : pos_triple_q;
          state_d      = en ? RUN : HOLD;
        end
      FLASH:
        if (tick_slow) begin
          phase_d = !phase_q;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == CW'(FLASH_TICKS - 1)) state_d = en ? RUN : HOLD;
        end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    led = state_q == FLASH ? {16{phase_q}} :
          (16'd1 << pos_single_q) | (16'd1 << pos_triple_q) |
          (16'd1 << (pos_triple_q + 4'd1)) | (16'd1 << (pos_triple_q - 4'd1));
  end
  assign pos_single = pos_single_q;
  assign pos_triple = pos_triple_q;
  assign state      = state_q;
  assign hit        = hit_q;
endmodule
